irq_pending83: RTL and testbench



---
 rtl/irq_pending83.sv | 136 +++++++++++++
 tb/tb_irq_pending83.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/irq_pending83.sv
// irq_pending83: eight-line request capture and serialisation stage.
// Rising edges on req are latched into a pending register. A two-state
// FSM presents the highest-priority unmasked pending line (bit 7 highest)
// as a held 3-bit code with a valid/ack handshake.
module irq_pending83 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] mask,
    input  logic       ack,
    output logic [2:0] code,
    output logic       valid,
    output logic [7:0] pending,
    output logic       overrun
);

    typedef enum logic [0:0] {
        StIdle,
        StPresent
    } state_e;

    state_e     r_state;
    state_e     w_state_d;

    logic [7:0] r_req_q;
    logic [7:0] r_pending;
    logic [7:0] w_pending_d;
    logic [7:0] w_edge;
    logic [7:0] w_clr;
    logic [7:0] w_avail;
    logic [2:0] r_code;
    logic [2:0] w_code_d;
    logic [2:0] w_top_idx;
    logic       r_valid;
    logic       w_valid_d;
    logic       r_overrun;
    logic       w_overrun_d;
    logic       w_ack_fire;

    // ack only counts while a code is actually presented
    assign w_ack_fire = (r_state == StPresent) && ack;
    assign w_edge     = req & ~r_req_q;
    assign w_avail    = r_pending & ~mask;

    // Highest set index of the serviceable pending lines; later hits override
    always_comb begin
        w_top_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_avail[i]) begin
                w_top_idx = 3'(i);
            end
        end
    end

    // One-hot clear for the line being acknowledged this cycle
    always_comb begin
        w_clr = 8'h00;
        if (w_ack_fire) begin
            w_clr[r_code] = 1'b1;
        end
    end

    // Pending and overrun next state; a new edge wins over a same-cycle clear
    always_comb begin
        w_pending_d = (r_pending & ~w_clr) | w_edge;
        w_overrun_d = r_overrun | (|(w_edge & r_pending & ~w_clr));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic: IDLE picks up any unmasked pending line, PRESENT waits for ack
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (|w_avail) begin
                    w_state_d = StPresent;
                end
            end
            StPresent: begin
                if (ack) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Output next-values: code latched on entry to PRESENT and held until ack
    always_comb begin
        w_code_d  = r_code;
        w_valid_d = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (|w_avail) begin
                    w_code_d  = w_top_idx;
                    w_valid_d = 1'b1;
                end
            end
            StPresent: begin
                w_valid_d = ~ack;
            end
            default: w_valid_d = 1'b0;
        endcase
    end

    // Registered datapath; req_q resets high so lines held through reset raise no edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_q   <= 8'hFF;
            r_pending <= 8'h00;
            r_code    <= 3'd0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_req_q   <= req;
            r_pending <= w_pending_d;
            r_code    <= w_code_d;
            r_valid   <= w_valid_d;
            r_overrun <= w_overrun_d;
        end
    end

    assign code    = r_code;
    assign valid   = r_valid;
    assign pending = r_pending;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_irq_pending83.sv
// Testbench for irq_pending83: table of per-cycle vectors with hand-derived
// expected post-edge state, routed through a scoreboard queue.
module tb_irq_pending83;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] mask;
        logic       ack;
        logic [7:0] e_pend;
        logic       e_valid;
        logic [2:0] e_code;
        logic       chk_code;
        logic       e_ovr;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[31];

    irq_pending83 u_dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .mask    (mask),
        .ack     (ack),
        .code    (code),
        .valid   (valid),
        .pending (pending),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [7:0] rq, input logic [7:0] mk_i,
                                input logic a, input logic [7:0] ep, input logic ev,
                                input logic [2:0] ec, input logic cc, input logic eo);
        vec_t v;
        v.rst = r; v.req = rq; v.mask = mk_i; v.ack = a;
        v.e_pend = ep; v.e_valid = ev; v.e_code = ec; v.chk_code = cc; v.e_ovr = eo;
        return v;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one vector away from the edge, then compare one cycle later
    task automatic step(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        rst  = v.rst;
        req  = v.req;
        mask = v.mask;
        ack  = v.ack;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_vec({tag, " pending"}, pending, e.e_pend);
        check_bit({tag, " valid"}, valid, e.e_valid);
        check_bit({tag, " overrun"}, overrun, e.e_ovr);
        if (e.chk_code) begin
            check_vec({tag, " code"}, {5'd0, code}, {5'd0, e.e_code});
        end
    endtask

    initial begin
        int lat;
        rst  = 1'b1;
        req  = 8'hFF;
        mask = 8'h00;
        ack  = 1'b0;

        // Reset then idle with req held high
        tbl[0]  = mk(1, 8'hFF, 8'h00, 0, 8'h00, 0, 3'd0, 1, 0);
        tbl[1]  = mk(1, 8'hFF, 8'h00, 0, 8'h00, 0, 3'd0, 1, 0);
        tbl[2]  = mk(0, 8'hFF, 8'h00, 0, 8'h00, 0, 3'd0, 1, 0);
        tbl[3]  = mk(0, 8'hFF, 8'h00, 0, 8'h00, 0, 3'd0, 0, 0);
        tbl[4]  = mk(0, 8'h00, 8'h00, 0, 8'h00, 0, 3'd0, 0, 0);
        // Single request on line 2
        tbl[5]  = mk(0, 8'h04, 8'h00, 0, 8'h04, 0, 3'd0, 0, 0);
        tbl[6]  = mk(0, 8'h04, 8'h00, 0, 8'h04, 1, 3'd2, 1, 0);
        tbl[7]  = mk(0, 8'h04, 8'h00, 1, 8'h00, 0, 3'd0, 0, 0);
        tbl[8]  = mk(0, 8'h00, 8'h00, 0, 8'h00, 0, 3'd0, 0, 0);
        // Priority 7,4,1 with ack held high (ignored while valid=0)
        tbl[9]  = mk(0, 8'h92, 8'h00, 0, 8'h92, 0, 3'd0, 0, 0);
        tbl[10] = mk(0, 8'h92, 8'h00, 0, 8'h92, 1, 3'd7, 1, 0);
        tbl[11] = mk(0, 8'h92, 8'h00, 1, 8'h12, 0, 3'd0, 0, 0);
        tbl[12] = mk(0, 8'h92, 8'h00, 1, 8'h12, 1, 3'd4, 1, 0);
        tbl[13] = mk(0, 8'h92, 8'h00, 1, 8'h02, 0, 3'd0, 0, 0);
        tbl[14] = mk(0, 8'h92, 8'h00, 1, 8'h02, 1, 3'd1, 1, 0);
        tbl[15] = mk(0, 8'h92, 8'h00, 1, 8'h00, 0, 3'd0, 0, 0);
        tbl[16] = mk(0, 8'h00, 8'h00, 0, 8'h00, 0, 3'd0, 0, 0);
        // Mask line 7, lines 7 and 3 pending
        tbl[17] = mk(0, 8'h88, 8'h80, 0, 8'h88, 0, 3'd0, 0, 0);
        tbl[18] = mk(0, 8'h88, 8'h80, 0, 8'h88, 1, 3'd3, 1, 0);
        tbl[19] = mk(0, 8'h88, 8'h80, 1, 8'h80, 0, 3'd0, 0, 0);
        tbl[20] = mk(0, 8'h00, 8'h80, 0, 8'h80, 0, 3'd0, 0, 0);
        tbl[21] = mk(0, 8'h00, 8'h00, 0, 8'h80, 1, 3'd7, 1, 0);
        tbl[22] = mk(0, 8'h00, 8'h00, 1, 8'h00, 0, 3'd0, 0, 0);
        // Edge on line 5 colliding with its own ack
        tbl[23] = mk(0, 8'h20, 8'h00, 0, 8'h20, 0, 3'd0, 0, 0);
        tbl[24] = mk(0, 8'h00, 8'h00, 0, 8'h20, 1, 3'd5, 1, 0);
        tbl[25] = mk(0, 8'h20, 8'h00, 1, 8'h20, 0, 3'd0, 0, 0);
        tbl[26] = mk(0, 8'h20, 8'h00, 0, 8'h20, 1, 3'd5, 1, 0);
        // Second edge on pending line 5 without ack sets overrun
        tbl[27] = mk(0, 8'h00, 8'h00, 0, 8'h20, 1, 3'd5, 1, 0);
        tbl[28] = mk(0, 8'h20, 8'h00, 0, 8'h20, 1, 3'd5, 1, 1);
        tbl[29] = mk(0, 8'h20, 8'h00, 1, 8'h00, 0, 3'd0, 0, 1);
        tbl[30] = mk(0, 8'h00, 8'h00, 0, 8'h00, 0, 3'd0, 0, 1);

        for (int i = 0; i < 31; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Hold: code 6 stays put while mask toggles and req[0] rises
        step(mk(0, 8'h40, 8'h00, 0, 8'h40, 0, 3'd0, 0, 1), "hold_set");
        step(mk(0, 8'h40, 8'h00, 0, 8'h40, 1, 3'd6, 1, 1), "hold_pres");
        for (int c = 0; c < 10; c++) begin
            logic [7:0] rq;
            logic [7:0] ep;
            rq = (c >= 3) ? 8'h41 : 8'h40;
            ep = (c >= 3) ? 8'h41 : 8'h40;
            step(mk(0, rq, (c % 2 == 0) ? 8'hFF : 8'h00, 0, ep, 1, 3'd6, 1, 1),
                 $sformatf("hold%0d", c));
        end

        // Reset mid-presentation
        step(mk(1, 8'h41, 8'h00, 0, 8'h00, 0, 3'd0, 1, 0), "rst_mid");
        step(mk(0, 8'h41, 8'h00, 0, 8'h00, 0, 3'd0, 1, 0), "rst_exit");

        // Bounded wait for request-to-valid latency on line 2
        @(negedge clk);
        req = 8'h04;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!valid && lat < 8);
        check_vec("latency", 8'(lat), 8'd2);
        check_vec("lat_code", {5'd0, code}, 8'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
